// File: rtl/pipe_pkg.sv
// Shared definitions for the MEM stage and the MEM/WB pipeline register.
//   WB_* : write-back mux select encodings
//   state_t : memory-access FSM states
//   memwb_t / MEMWB_BUBBLE : MEM/WB bundle and the value it takes for a bubble
package pipe_pkg;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_NPC = 2'd1;
    localparam logic [1:0] WB_MEM = 2'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] aluout;
        logic [31:0] memout;
        logic [31:0] npc;
        logic [4:0]  rd;
        logic        regwr;
        logic [1:0]  wbdata;
    } memwb_t;

    localparam memwb_t MEMWB_BUBBLE = '0;

endpackage

// File: rtl/mem_stage_data_ram.sv
// Word-addressed data RAM, 2**ADDR_W x 32.
//   clk   : write clock
//   we    : write enable
//   waddr : write word index
//   wdata : write data
//   raddr : read word index
//   rdata : combinational read data
// Contents are deliberately not reset.
module data_ram #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_stage.sv
// Memory stage plus MEM/WB pipeline register.
//   clk, reset_n        : clock, async active-low reset
//   valid2 .. WBdata2   : EX/MEM bundle (held stable while memStall=1)
//   memStall            : combinational; freezes IF..EX during multi-cycle accesses
//   ALUout3 .. WBdata3  : registered MEM/WB bundle to the write-back mux
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no access in flight; non-memory ops complete in one cycle
// ST_WAIT | load/store in flight; completes on the edge where cnt==0
module mem_stage
    import pipe_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        valid2,
    input  logic [31:0] ALUout2,
    input  logic [31:0] storeData,
    input  logic [31:0] NPC2,
    input  logic [4:0]  Rd2,
    input  logic        RegWr2,
    input  logic        MemRd2,
    input  logic        MemWr2,
    input  logic [1:0]  WBdata2,
    output logic        memStall,
    output logic [31:0] ALUout3,
    output logic [31:0] MemOut,
    output logic [31:0] NPC3,
    output logic [4:0]  Rd3,
    output logic        RegWr3,
    output logic [1:0]  WBdata3
);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    memwb_t             memwb, memwb_nxt;
    logic               access;
    logic               is_store;
    logic               ram_we;
    logic [ADDR_W-1:0]  idx;
    logic [31:0]        ram_rdata;
    logic               unused_addr_bits;

    assign access   = valid2 & (MemRd2 | MemWr2);
    assign is_store = MemWr2;
    assign idx      = ALUout2[ADDR_W+1:2];

    // Byte offset and bits above the RAM depth are ignored: addresses wrap.
    assign unused_addr_bits = ^{ALUout2[31:ADDR_W+2], ALUout2[1:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            memwb <= MEMWB_BUBBLE;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            memwb <= memwb_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        memStall  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (access && (MEM_LAT > 0)) begin
                    memStall  = 1'b1;
                    state_nxt = ST_WAIT;
                    cnt_nxt   = CNT_W'(MEM_LAT - 1);
                end
            end
            ST_WAIT: begin
                if (cnt != '0) begin
                    memStall = 1'b1;
                    cnt_nxt  = cnt - 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // A store writes exactly once, on its completing (non-stalled) edge.
    // Gating with reset_n keeps an aborted access from landing in RAM.
    assign ram_we = access & is_store & ~memStall & reset_n;

    always_comb begin
        memwb_nxt = MEMWB_BUBBLE;
        if (!memStall && valid2) begin
            memwb_nxt.aluout = ALUout2;
            memwb_nxt.npc    = NPC2;
            memwb_nxt.rd     = Rd2;
            memwb_nxt.regwr  = RegWr2;
            memwb_nxt.wbdata = WBdata2;
            // MemRd2 & MemWr2 together behave as a store, so no load data.
            memwb_nxt.memout = (MemRd2 && !MemWr2) ? ram_rdata : 32'd0;
        end
    end

    data_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (idx),
        .wdata (storeData),
        .raddr (idx),
        .rdata (ram_rdata)
    );

    assign ALUout3 = memwb.aluout;
    assign MemOut  = memwb.memout;
    assign NPC3    = memwb.npc;
    assign Rd3     = memwb.rd;
    assign RegWr3  = memwb.regwr;
    assign WBdata3 = memwb.wbdata;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    localparam int ADDR_W  = 8;
    localparam int MEM_LAT = 2;
    localparam int DEPTH   = 2**ADDR_W;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        valid2;
    logic [31:0] ALUout2, storeData, NPC2;
    logic [4:0]  Rd2;
    logic        RegWr2, MemRd2, MemWr2;
    logic [1:0]  WBdata2;
    logic        memStall;
    logic [31:0] ALUout3, MemOut, NPC3;
    logic [4:0]  Rd3;
    logic        RegWr3;
    logic [1:0]  WBdata3;

    typedef struct {
        logic [31:0] aluout;
        logic [31:0] memout;
        logic [31:0] npc;
        logic [4:0]  rd;
        logic        regwr;
        logic [1:0]  wbdata;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ram_model [DEPTH];
    int          checks = 0;
    int          errors = 0;

    mem_stage #(.ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT), .CNT_W(2)) dut (
        .clk(clk), .reset_n(reset_n), .valid2(valid2), .ALUout2(ALUout2),
        .storeData(storeData), .NPC2(NPC2), .Rd2(Rd2), .RegWr2(RegWr2),
        .MemRd2(MemRd2), .MemWr2(MemWr2), .WBdata2(WBdata2),
        .memStall(memStall), .ALUout3(ALUout3), .MemOut(MemOut), .NPC3(NPC3),
        .Rd3(Rd3), .RegWr3(RegWr3), .WBdata3(WBdata3)
    );

    always #5 clk = ~clk;

    function automatic exp_t bubble(string tag);
        exp_t e;
        e.aluout = 0; e.memout = 0; e.npc = 0; e.rd = 0; e.regwr = 0; e.wbdata = 0;
        e.tag = tag;
        return e;
    endfunction

    // Monitor: after every edge, compare the MEM/WB outputs against the oldest expectation.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (reset_n && sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (ALUout3 !== e.aluout || MemOut !== e.memout || NPC3 !== e.npc ||
                    Rd3 !== e.rd || RegWr3 !== e.regwr || WBdata3 !== e.wbdata) begin
                    errors++;
                    $display("FAIL %s: got alu=%h mem=%h npc=%h rd=%0d rw=%0d wb=%0d expected alu=%h mem=%h npc=%h rd=%0d rw=%0d wb=%0d",
                             e.tag, ALUout3, MemOut, NPC3, Rd3, RegWr3, WBdata3,
                             e.aluout, e.memout, e.npc, e.rd, e.regwr, e.wbdata);
                end
            end
        end
    end

    // Issue one instruction (entered and left at posedge+1), holding inputs
    // through any stall; the reference model decides latency and result.
    task automatic do_op(input string tag, input logic v, input logic mrd, input logic mwr,
                         input logic [31:0] alu, input logic [31:0] sd,
                         input logic [31:0] npc, input logic [4:0] rd,
                         input logic rw, input logic [1:0] wb);
        int   lat;
        int   w;
        exp_t e;
        valid2 = v; MemRd2 = mrd; MemWr2 = mwr; ALUout2 = alu; storeData = sd;
        NPC2 = npc; Rd2 = rd; RegWr2 = rw; WBdata2 = wb;
        lat = (v && (mrd || mwr)) ? MEM_LAT : 0;
        w   = int'((alu / 4) % DEPTH);
        for (int c = 0; c <= lat; c++) begin
            @(negedge clk);
            checks++;
            if (memStall !== (c < lat)) begin
                errors++;
                $display("FAIL %s stall cycle %0d: got %b expected %b", tag, c, memStall, (c < lat));
            end
            if (c < lat) begin
                sb.push_back(bubble({tag, " bubble"}));
            end else if (!v) begin
                sb.push_back(bubble(tag));
            end else begin
                e.aluout = alu; e.npc = npc; e.rd = rd; e.regwr = rw; e.wbdata = wb; e.tag = tag;
                e.memout = (mrd && !mwr) ? ram_model[w] : 32'd0;
                sb.push_back(e);
                if (mwr) ram_model[w] = sd;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_zero(string tag);
        checks++;
        if (memStall !== 1'b0 || ALUout3 !== 0 || MemOut !== 0 || NPC3 !== 0 ||
            Rd3 !== 0 || RegWr3 !== 0 || WBdata3 !== 0) begin
            errors++;
            $display("FAIL %s: got stall=%b alu=%h mem=%h npc=%h rd=%0d rw=%0d wb=%0d expected all zero",
                     tag, memStall, ALUout3, MemOut, NPC3, Rd3, RegWr3, WBdata3);
        end
    endtask

    initial begin
        reset_n = 1'b0; valid2 = 0; ALUout2 = 0; storeData = 0; NPC2 = 0;
        Rd2 = 0; RegWr2 = 0; MemRd2 = 0; MemWr2 = 0; WBdata2 = 0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_initial");
        reset_n = 1'b1;

        // Give every RAM word a known value so any random load is predictable.
        for (int i = 0; i < DEPTH; i++)
            do_op("preload", 1, 0, 1, 32'(i * 4), $urandom, 0, 0, 0, 2'd0);

        do_op("alu_op", 1, 0, 0, 32'h1234, 32'h0, 32'h40, 5'd7, 1, 2'd0);
        do_op("store_20", 1, 0, 1, 32'h20, 32'hDEADBEEF, 32'h44, 5'd0, 0, 2'd0);
        do_op("load_20", 1, 1, 0, 32'h20, 32'h0, 32'h48, 5'd9, 1, 2'd2);
        do_op("store_wrap", 1, 0, 1, 32'h403, 32'h55, 32'h4C, 5'd0, 0, 2'd0);
        do_op("load_0", 1, 1, 0, 32'h000, 32'h0, 32'h50, 5'd3, 1, 2'd2);
        do_op("jal_link", 1, 0, 0, 32'h0, 32'h0, 32'h104, 5'd31, 1, 2'd1);
        do_op("bubble", 0, 0, 0, 32'hFFFF, 32'h0, 32'h108, 5'd31, 1, 2'd1);
        do_op("rd_and_wr", 1, 1, 1, 32'h30, 32'h0BADF00D, 32'h10C, 5'd5, 0, 2'd2);
        do_op("load_30", 1, 1, 0, 32'h30, 32'h0, 32'h110, 5'd6, 1, 2'd2);

        // Reset in the middle of a store to 0x10: the write must never happen.
        valid2 = 1; MemRd2 = 0; MemWr2 = 1; ALUout2 = 32'h10; storeData = 32'hCAFE0000;
        NPC2 = 0; Rd2 = 0; RegWr2 = 0; WBdata2 = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        valid2  = 1'b0;
        #1;
        check_zero("reset_mid_wait");
        @(posedge clk);
        #1;
        check_zero("reset_held");
        reset_n = 1'b1;
        do_op("load_10_after_abort", 1, 1, 0, 32'h10, 32'h0, 32'h0, 5'd4, 1, 2'd2);

        for (int n = 0; n < 300; n++) begin
            logic        v, mrd, mwr, rw;
            logic [31:0] alu;
            v   = ($urandom_range(0, 7) != 0);
            mrd = $urandom_range(0, 1) == 1;
            mwr = $urandom_range(0, 2) == 0;
            rw  = $urandom_range(0, 1) == 1;
            alu = $urandom;
            do_op("random", v, mrd, mwr, alu, $urandom, $urandom, 5'($urandom),
                  rw, 2'($urandom_range(0, 2)));
        end

        valid2 = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
